// File: rtl/shared_reg_arbiter_if.sv
// Bus between the requesters and the shared-register arbiter.
//   req/lock/wdata : requester -> arbiter (one bit / one WIDTH slice per requester)
//   gnt/ack        : arbiter -> requesters, one-hot or zero
//   q/q_valid      : shared register contents and "written since reset" flag
//   owner/busy     : current owner index (meaningful while busy) and GRANT state
interface shared_reg_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int OW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [NREQ-1:0]       lock;
  logic [NREQ*WIDTH-1:0] wdata;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      q;
  logic                  q_valid;
  logic [OW-1:0]         owner;
  logic                  busy;

  modport master (output req, lock, wdata,
                  input  gnt, ack, q, q_valid, owner, busy);
  modport slave  (input  req, lock, wdata,
                  output gnt, ack, q, q_valid, owner, busy);
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and write sequencer for one shared WIDTH-bit register.
// The owner may lock for up to MAX_BURST back-to-back writes; every write is
// acknowledged one cycle later and a dead IDLE cycle separates owners.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of shared_reg_arbiter_if (req/lock/wdata in,
//           gnt/ack/q/q_valid/owner/busy out)
module shared_reg_arbiter #(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                reset,
  shared_reg_arbiter_if.slave bus
);
  localparam int          OW = $clog2(NREQ);
  localparam int          CW = $clog2(MAX_BURST + 1);
  localparam int unsigned NR = NREQ;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state, state_n;
  logic [NREQ-1:0]  gnt_r, gnt_n;
  logic [NREQ-1:0]  ack_r, ack_n;
  logic [WIDTH-1:0] q_r, q_n, wsel;
  logic             qv_r, qv_n;
  logic [OW-1:0]    owner_r, owner_n;
  logic [OW-1:0]    ptr_r, ptr_n;
  logic [OW-1:0]    cand;
  logic [CW-1:0]    cnt_r, cnt_n, cnt_inc;
  logic             found;
  logic             release_o;

  // Owner's data slice, selected with constant indices only.
  always_comb begin
    wsel = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      if (owner_r == OW'(i)) wsel = bus.wdata[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_n   = state;
    gnt_n     = gnt_r;
    ack_n     = '0;
    q_n       = q_r;
    qv_n      = qv_r;
    owner_n   = owner_r;
    ptr_n     = ptr_r;
    cnt_n     = cnt_r;
    cnt_inc   = cnt_r + CW'(1);
    found     = 1'b0;
    cand      = '0;
    release_o = 1'b0;
    unique case (state)
      IDLE: begin
        // Scan ptr, ptr+1, ... wrapping; first requester found wins.
        for (int unsigned k = 0; k < NR; k++) begin
          cand = OW'((32'(ptr_r) + k) % NR);
          if (!found && bus.req[cand]) begin
            found       = 1'b1;
            owner_n     = cand;
            gnt_n       = '0;
            gnt_n[cand] = 1'b1;
          end
        end
        if (found) begin
          cnt_n   = '0;
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (bus.req[owner_r]) begin
          q_n            = wsel;
          qv_n           = 1'b1;
          ack_n[owner_r] = 1'b1;
          cnt_n          = cnt_inc;
          // Counter never wraps: hitting MAX_BURST forces release.
          release_o = !bus.lock[owner_r] || (cnt_inc == CW'(MAX_BURST));
        end else begin
          release_o = 1'b1;
        end
        if (release_o) begin
          gnt_n   = '0;
          ptr_n   = (owner_r == OW'(NREQ - 1)) ? '0 : owner_r + OW'(1);
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      gnt_r   <= '0;
      ack_r   <= '0;
      q_r     <= '0;
      qv_r    <= 1'b0;
      owner_r <= '0;
      ptr_r   <= '0;
      cnt_r   <= '0;
    end else begin
      state   <= state_n;
      gnt_r   <= gnt_n;
      ack_r   <= ack_n;
      q_r     <= q_n;
      qv_r    <= qv_n;
      owner_r <= owner_n;
      ptr_r   <= ptr_n;
      cnt_r   <= cnt_n;
    end
  end

  assign bus.gnt     = gnt_r;
  assign bus.ack     = ack_r;
  assign bus.q       = q_r;
  assign bus.q_valid = qv_r;
  assign bus.owner   = owner_r;
  assign bus.busy    = (state == GRANT);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
module tb_shared_reg_arbiter;
  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int MAX_BURST = 4;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  shared_reg_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MAX_BURST(MAX_BURST)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner index (-1 when nobody owns), round-robin pointer,
  // writes done in the current ownership, register value, last-cycle ack.
  int          m_owner;
  int          m_ptr;
  int          m_cnt;
  logic [7:0]  m_q;
  logic        m_qv;
  logic [3:0]  m_ack;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [3:0]  lock;
    logic [31:0] wdata;
    logic [3:0]  egnt;
    logic [3:0]  eack;
    logic [7:0]  eq;
    logic        eqv;
    logic        ebusy;
  } vec_t;

  vec_t tbl[18];

  function automatic logic [31:0] sl(input int i, input logic [7:0] v);
    return 32'(v) << (8 * i);
  endfunction

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'h1) != 4'h0;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                            input logic [31:0] wd);
    if (r) begin
      m_owner = -1; m_ptr = 0; m_cnt = 0; m_q = 8'h00; m_qv = 1'b0; m_ack = 4'h0;
    end else if (m_owner < 0) begin
      m_ack = 4'h0;
      for (int k = 0; k < NREQ; k++) begin
        if (m_owner < 0 && bit_of(rq, (m_ptr + k) % NREQ)) begin
          m_owner = (m_ptr + k) % NREQ;
          m_cnt   = 0;
        end
      end
    end else begin
      bit rel;
      m_ack = 4'h0;
      rel   = 1'b1;
      if (bit_of(rq, m_owner)) begin
        m_q   = 8'((wd >> (8 * m_owner)) & 32'hFF);
        m_qv  = 1'b1;
        m_ack = 4'(1 << m_owner);
        m_cnt = m_cnt + 1;
        rel   = !bit_of(lk, m_owner) || (m_cnt == MAX_BURST);
      end
      if (rel) begin
        m_ptr   = (m_owner + 1) % NREQ;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                       input logic [31:0] wd);
    rst       = r;
    bus.req   = rq;
    bus.lock  = lk;
    bus.wdata = wd;
    @(posedge clk);
    model_step(r, rq, lk, wd);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic [3:0] a,
                            input logic [7:0] qe, input logic qv, input logic b);
    chk({nm, ".gnt"},     32'(bus.gnt),     32'(g));
    chk({nm, ".ack"},     32'(bus.ack),     32'(a));
    chk({nm, ".q"},       32'(bus.q),       32'(qe));
    chk({nm, ".q_valid"}, 32'(bus.q_valid), 32'(qv));
    chk({nm, ".busy"},    32'(bus.busy),    32'(b));
  endtask

  initial begin
    logic [31:0] d4;
    n_tests = 0;
    n_fail  = 0;
    m_owner = -1; m_ptr = 0; m_cnt = 0; m_q = 8'h00; m_qv = 1'b0; m_ack = 4'h0;
    rst = 1'b1; bus.req = '0; bus.lock = '0; bus.wdata = '0;
    d4 = 32'h13121110;

    // Reset x3, single write by 2, then all-request round robin from ptr=3.
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 32'h0,        4'h0, 4'h0, 8'h00, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 4'h4, 4'h0, 32'h00A50000, 4'h4, 4'h0, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 4'h4, 4'h0, 32'h00A50000, 4'h0, 4'h4, 8'hA5, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 8'hA5, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 4'hF, 4'h0, d4,           4'h8, 4'h0, 8'hA5, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 4'hF, 4'h0, d4,           4'h0, 4'h8, 8'h13, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, d4,           4'h1, 4'h0, 8'h13, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 4'hF, 4'h0, d4,           4'h0, 4'h1, 8'h10, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 4'h0, d4,           4'h2, 4'h0, 8'h10, 1'b1, 1'b1};
    tbl[11] = '{1'b0, 4'hF, 4'h0, d4,           4'h0, 4'h2, 8'h11, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'hF, 4'h0, d4,           4'h4, 4'h0, 8'h11, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 4'hF, 4'h0, d4,           4'h0, 4'h4, 8'h12, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'hF, 4'h0, d4,           4'h8, 4'h0, 8'h12, 1'b1, 1'b1};
    tbl[15] = '{1'b0, 4'hF, 4'h0, d4,           4'h0, 4'h8, 8'h13, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'hF, 4'h0, d4,           4'h1, 4'h0, 8'h13, 1'b1, 1'b1};
    tbl[17] = '{1'b1, 4'h0, 4'h0, 32'h0,        4'h0, 4'h0, 8'h00, 1'b0, 1'b0};

    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].lock, tbl[i].wdata);
      expect_out($sformatf("vec%0d", i), tbl[i].egnt, tbl[i].eack, tbl[i].eq,
                 tbl[i].eqv, tbl[i].ebusy);
    end

    // Burst cap: requester 1 locked, data 1..5; only 1..4 land in this ownership.
    drive(1'b0, 4'h2, 4'h2, sl(1, 8'h00));
    expect_out("burst.grant", 4'h2, 4'h0, 8'h00, 1'b0, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      drive(1'b0, 4'h2, 4'h2, sl(1, 8'(k)));
      expect_out($sformatf("burst.w%0d", k), (k == 4) ? 4'h0 : 4'h2, 4'h2, 8'(k), 1'b1,
                 k != 4);
    end
    drive(1'b0, 4'h2, 4'h2, sl(1, 8'h05));
    expect_out("burst.regrant", 4'h2, 4'h0, 8'h04, 1'b1, 1'b1);
    drive(1'b0, 4'h2, 4'h2, sl(1, 8'h05));
    expect_out("burst.w5", 4'h2, 4'h2, 8'h05, 1'b1, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    expect_out("burst.drop", 4'h0, 4'h0, 8'h05, 1'b1, 1'b0);

    // Reset mid-burst (ptr is 2 beforehand), then check scan restarts at 0.
    drive(1'b0, 4'h2, 4'h2, sl(1, 8'h30));
    expect_out("rstmid.grant", 4'h2, 4'h0, 8'h05, 1'b1, 1'b1);
    drive(1'b0, 4'h2, 4'h2, sl(1, 8'h31));
    expect_out("rstmid.w1", 4'h2, 4'h2, 8'h31, 1'b1, 1'b1);
    drive(1'b0, 4'h2, 4'h2, sl(1, 8'h32));
    expect_out("rstmid.w2", 4'h2, 4'h2, 8'h32, 1'b1, 1'b1);
    drive(1'b1, 4'h2, 4'h2, sl(1, 8'h33));
    expect_out("rstmid.rst", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 4'h5, 4'h0, 32'h0);
    expect_out("rstmid.ptr0", 4'h1, 4'h0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    expect_out("rstmid.nowrite", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 4'h4, 4'h0, sl(2, 8'h44));
    expect_out("rstmid.g2", 4'h4, 4'h0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 4'h4, 4'h0, sl(2, 8'h44));
    expect_out("rstmid.w2b", 4'h0, 4'h4, 8'h44, 1'b1, 1'b0);

    // Owner 0 drops req after 2 locked writes; requester 3 follows 2 edges later.
    drive(1'b1, 4'h0, 4'h0, 32'h0);
    expect_out("drop.rst", 4'h0, 4'h0, 8'h00, 1'b0, 1'b0);
    drive(1'b0, 4'h9, 4'h1, sl(0, 8'h20) | sl(3, 8'hEE));
    expect_out("drop.grant", 4'h1, 4'h0, 8'h00, 1'b0, 1'b1);
    drive(1'b0, 4'h9, 4'h1, sl(0, 8'h21) | sl(3, 8'hEE));
    expect_out("drop.w1", 4'h1, 4'h1, 8'h21, 1'b1, 1'b1);
    drive(1'b0, 4'h9, 4'h1, sl(0, 8'h22) | sl(3, 8'hEE));
    expect_out("drop.w2", 4'h1, 4'h1, 8'h22, 1'b1, 1'b1);
    drive(1'b0, 4'h8, 4'h1, sl(0, 8'h23) | sl(3, 8'hEE));
    expect_out("drop.rel", 4'h0, 4'h0, 8'h22, 1'b1, 1'b0);
    drive(1'b0, 4'h8, 4'h0, sl(3, 8'hEE));
    expect_out("drop.g3", 4'h8, 4'h0, 8'h22, 1'b1, 1'b1);
    drive(1'b0, 4'h8, 4'h0, sl(3, 8'hEE));
    expect_out("drop.w3", 4'h0, 4'h8, 8'hEE, 1'b1, 1'b0);

    // Random traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      logic        r;
      logic [3:0]  rq, lk;
      logic [31:0] wd;
      r  = ($urandom_range(0, 79) == 0);
      rq = 4'($urandom) & 4'($urandom | $urandom);
      lk = 4'($urandom);
      wd = $urandom;
      drive(r, rq, lk, wd);
      chk("rnd.gnt",     32'(bus.gnt),     (m_owner >= 0) ? (32'h1 << m_owner) : 32'h0);
      chk("rnd.ack",     32'(bus.ack),     32'(m_ack));
      chk("rnd.q",       32'(bus.q),       32'(m_q));
      chk("rnd.q_valid", 32'(bus.q_valid), 32'(m_qv));
      chk("rnd.busy",    32'(bus.busy),    32'(m_owner >= 0));
      if (m_owner >= 0) chk("rnd.owner", 32'(bus.owner), 32'(m_owner));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
